line_stream_ctrl: RTL and testbench

//  Front end of the line-buffer chain. Converts a raw video pixel stream into the

---
 rtl/line_stream_pkg.sv | 14 +
 rtl/edge_det.sv | 22 ++
 rtl/line_stream_ctrl.sv | 149 ++++++++++++++
 tb/tb_line_stream_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/line_stream_pkg.sv
// Shared types and default geometry for the line-stream front end.
package line_stream_pkg;

   typedef enum logic [1:0] {WAIT_VS, WAIT_LINE, ACTIVE, BLANK} ls_state_t;

   localparam int DEF_COLORDEPTH   = 8;
   localparam int DEF_SCREENWIDTH  = 1600;
   localparam int DEF_SCREENHEIGHT = 900;
   localparam int DEF_BUF_DEPTH    = 3;

   localparam int XW = $clog2(DEF_SCREENWIDTH);
   localparam int YW = $clog2(DEF_SCREENHEIGHT);

endpackage

// File: rtl/edge_det.sv
// One-bit input register with rise/fall strobes (current input vs registered copy).
module edge_det
   import line_stream_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic d_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) d_q <= 1'b0;
      else      d_q <= d_i;
   end

   assign rise_o = d_i & ~d_q;
   assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/line_stream_ctrl.sv
// Line-stream front end: turns vsync/de/pixel input into registered pixel, valid,
// line-end and coordinate outputs for the line buffer, with line-length checking.
module line_stream_ctrl
   import line_stream_pkg::*;
#(
   parameter int COLORDEPTH   = DEF_COLORDEPTH,
   parameter int SCREENWIDTH  = DEF_SCREENWIDTH,
   parameter int SCREENHEIGHT = DEF_SCREENHEIGHT,
   parameter int BUF_DEPTH    = DEF_BUF_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            vs_i,
   input  logic                            de_i,
   input  logic [COLORDEPTH-1:0]           data_i,
   output logic [COLORDEPTH-1:0]           data_o,
   output logic                            dv_o,
   output logic                            line_end_o,
   output logic                            frame_start_o,
   output logic [$clog2(SCREENWIDTH)-1:0]  x_o,
   output logic [$clog2(SCREENHEIGHT)-1:0] y_o,
   output logic                            win_valid_o,
   output logic                            err_o,
   output ls_state_t                       state_o
);

   localparam int LXW = $clog2(SCREENWIDTH);
   localparam int LYW = $clog2(SCREENHEIGHT);

   localparam logic [LXW:0]   CNT_ONE  = (LXW+1)'(1);
   localparam logic [LXW:0]   CNT_FULL = (LXW+1)'(SCREENWIDTH);
   localparam logic [LXW-1:0] X_LAST   = LXW'(SCREENWIDTH-1);
   localparam logic [LYW-1:0] Y_ONE    = LYW'(1);
   localparam logic [LYW-1:0] Y_LAST   = LYW'(SCREENHEIGHT-1);
   localparam logic [LYW-1:0] Y_WIN    = LYW'(BUF_DEPTH-1);

   logic vs_rise, vs_fall_unused;
   logic de_rise, de_fall;

   edge_det u_vs_edge (
      .clk    (clk),
      .rst    (rst),
      .d_i    (vs_i),
      .rise_o (vs_rise),
      .fall_o (vs_fall_unused)
   );

   edge_det u_de_edge (
      .clk    (clk),
      .rst    (rst),
      .d_i    (de_i),
      .rise_o (de_rise),
      .fall_o (de_fall)
   );

   ls_state_t             state_q;
   logic [COLORDEPTH-1:0] data_q;
   logic                  dv_q, line_end_q, frame_start_q, err_q, done_q;
   logic [LXW-1:0]        x_q;
   logic [LYW-1:0]        y_q;
   // Pixels seen on the current line; one bit wider so it can hold SCREENWIDTH.
   logic [LXW:0]          cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= WAIT_VS;
         data_q        <= '0;
         dv_q          <= 1'b0;
         line_end_q    <= 1'b0;
         frame_start_q <= 1'b0;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         cnt_q         <= '0;
      end else begin
         data_q        <= data_i;
         dv_q          <= 1'b0;
         line_end_q    <= 1'b0;
         frame_start_q <= 1'b0;
         if (vs_rise) begin
            // Frame start overrides everything, including a truncated-line error.
            frame_start_q <= 1'b1;
            line_end_q    <= (state_q == ACTIVE);
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            state_q       <= WAIT_LINE;
         end else begin
            case (state_q)
               WAIT_VS: begin
                  if (de_rise && done_q) err_q <= 1'b1;
               end
               WAIT_LINE: begin
                  if (de_i) begin
                     state_q <= ACTIVE;
                     dv_q    <= 1'b1;
                     x_q     <= '0;
                     cnt_q   <= CNT_ONE;
                  end
               end
               ACTIVE: begin
                  if (de_fall) begin
                     line_end_q <= 1'b1;
                     if (cnt_q != CNT_FULL) err_q <= 1'b1;
                     if (y_q == Y_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= WAIT_VS;
                     end else begin
                        y_q     <= y_q + Y_ONE;
                        state_q <= BLANK;
                     end
                  end else if (cnt_q < CNT_FULL) begin
                     dv_q  <= 1'b1;
                     x_q   <= cnt_q[LXW-1:0];
                     cnt_q <= cnt_q + CNT_ONE;
                  end else begin
                     // Overlong line: hold the address, suppress valid.
                     x_q   <= X_LAST;
                     err_q <= 1'b1;
                  end
               end
               BLANK: begin
                  if (de_rise) begin
                     state_q <= ACTIVE;
                     dv_q    <= 1'b1;
                     x_q     <= '0;
                     cnt_q   <= CNT_ONE;
                  end
               end
               default: state_q <= WAIT_VS;
            endcase
         end
      end
   end

   assign data_o        = data_q;
   assign dv_o          = dv_q;
   assign line_end_o    = line_end_q;
   assign frame_start_o = frame_start_q;
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign err_o         = err_q;
   assign state_o       = state_q;
   assign win_valid_o   = dv_q && (y_q >= Y_WIN);

endmodule

// File: tb/tb_line_stream_ctrl.sv
// Directed bench: full-size instance for line/pixel behaviour, small-width
// instance for the frame-height limit.
module tb_line_stream_ctrl;
   import line_stream_pkg::*;

   localparam int W_A = 1600;

   logic       clk = 1'b0;
   logic       rst;
   logic       vs_i, de_i;
   logic [7:0] data_i;

   logic [7:0]    a_data, b_data;
   logic          a_dv, a_le, a_fs, a_wv, a_err;
   logic          b_dv, b_le, b_fs, b_wv, b_err;
   logic [XW-1:0] a_x;
   logic [YW-1:0] a_y;
   logic [1:0]    b_x;
   logic [9:0]    b_y;
   ls_state_t     a_state, b_state;

   int n_cmp = 0;
   int n_err = 0;
   int a_dv_cnt, a_le_cnt, a_fs_cnt, a_wv_cnt, b_dv_cnt, b_le_cnt;
   int pix_bad, le_bad;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   line_stream_ctrl u_dut_a (
      .clk(clk), .rst(rst), .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
      .data_o(a_data), .dv_o(a_dv), .line_end_o(a_le), .frame_start_o(a_fs),
      .x_o(a_x), .y_o(a_y), .win_valid_o(a_wv), .err_o(a_err), .state_o(a_state)
   );

   line_stream_ctrl #(.COLORDEPTH(8), .SCREENWIDTH(4), .SCREENHEIGHT(900), .BUF_DEPTH(3)) u_dut_b (
      .clk(clk), .rst(rst), .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
      .data_o(b_data), .dv_o(b_dv), .line_end_o(b_le), .frame_start_o(b_fs),
      .x_o(b_x), .y_o(b_y), .win_valid_o(b_wv), .err_o(b_err), .state_o(b_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      a_dv_cnt = 0; a_le_cnt = 0; a_fs_cnt = 0; a_wv_cnt = 0;
      b_dv_cnt = 0; b_le_cnt = 0; pix_bad = 0; le_bad = 0;
   endtask

   task automatic cyc(input logic vs, input logic de, input logic [7:0] d);
      vs_i = vs; de_i = de; data_i = d;
      @(posedge clk); #1;
      if (a_dv) a_dv_cnt++;
      if (a_le) a_le_cnt++;
      if (a_fs) a_fs_cnt++;
      if (a_wv) a_wv_cnt++;
      if (b_dv) b_dv_cnt++;
      if (b_le) b_le_cnt++;
   endtask

   task automatic drive_line(input int npix, input int nblank, input int exp_y);
      logic [7:0] d;
      logic [7:0] e;
      for (int i = 0; i < npix; i++) begin
         d = 8'(i ^ 32'h5A);
         if (i < W_A) exp_q.push_back(d);
         cyc(1'b0, 1'b1, d);
         if (a_dv) begin
            if (exp_q.size() == 0) pix_bad++;
            else begin
               e = exp_q.pop_front();
               if (a_data !== e) pix_bad++;
            end
            if (int'(a_x) != i || int'(a_y) != exp_y) pix_bad++;
         end else if (i < W_A || int'(a_x) != W_A - 1) pix_bad++;
      end
      for (int i = 0; i < nblank; i++) begin
         cyc(1'b0, 1'b0, 8'h00);
         if (a_dv) pix_bad++;
         if ((i == 0) != a_le) le_bad++;
      end
   endtask

   task automatic b_line(input int npix);
      for (int p = 0; p < npix; p++) cyc(1'b0, 1'b1, 8'(p));
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; vs_i = 1'b0; de_i = 1'b0; data_i = 8'h00;
      clr_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dv",    32'(a_dv), 0);
      chk("reset_flags", 32'({a_le, a_fs, a_wv, a_err}), 0);
      chk("reset_xy",    32'({a_x, a_y}), 0);
      chk("reset_state", 32'(a_state), 32'(WAIT_VS));
      rst = 1'b1;

      // 1: reset mid-line, then de ignored without a vs rise
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'(i));
      chk("t1_pre_rst_dv", 32'(a_dv), 1);
      chk("t1_pre_rst_x",  32'(a_x), 9);
      rst = 1'b0;
      #1;
      chk("t1_async_dv",    32'(a_dv), 0);
      chk("t1_async_outs",  32'({a_data, a_x, a_y, a_le, a_fs, a_wv, a_err}), 0);
      chk("t1_async_state", 32'(a_state), 32'(WAIT_VS));
      @(posedge clk); #1;
      rst = 1'b1;
      clr_stats();
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'(i));
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00);
      chk("t1_ignored_dv", 32'(a_dv_cnt), 0);
      chk("t1_ignored_le", 32'(a_le_cnt), 0);
      chk("t1_err",        32'(a_err), 0);

      // 2: three full lines
      clr_stats();
      cyc(1'b1, 1'b0, 8'h00);
      chk("t2_frame_start", 32'(a_fs), 1);
      chk("t2_state",       32'(a_state), 32'(WAIT_LINE));
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      for (int l = 0; l < 3; l++) drive_line(1600, 200, l);
      chk("t2_dv_cycles", 32'(a_dv_cnt), 4800);
      chk("t2_line_ends", 32'(a_le_cnt), 3);
      chk("t2_pix_bad",   32'(pix_bad), 0);
      chk("t2_le_bad",    32'(le_bad), 0);
      chk("t2_win_cycles",32'(a_wv_cnt), 1600);
      chk("t2_err",       32'(a_err), 0);
      chk("t2_y_after",   32'(a_y), 3);
      chk("t2_fs_count",  32'(a_fs_cnt), 1);

      // 3: short line sets sticky error, cleared by next vs rise
      clr_stats();
      drive_line(1599, 200, 3);
      chk("t3_err_set",   32'(a_err), 1);
      chk("t3_le_bad",    32'(le_bad), 0);
      drive_line(1600, 200, 4);
      chk("t3_err_sticky",32'(a_err), 1);
      chk("t3_pix_bad",   32'(pix_bad), 0);
      cyc(1'b1, 1'b0, 8'h00);
      chk("t3_err_clear", 32'(a_err), 0);
      chk("t3_fs",        32'(a_fs), 1);
      cyc(1'b0, 1'b0, 8'h00);

      // 4: overlong line
      clr_stats();
      drive_line(1605, 200, 0);
      chk("t4_dv_cycles", 32'(a_dv_cnt), 1600);
      chk("t4_pix_bad",   32'(pix_bad), 0);
      chk("t4_le_bad",    32'(le_bad), 0);
      chk("t4_err",       32'(a_err), 1);
      chk("t4_exp_q",     32'(exp_q.size()), 0);

      // 5: vs rise in the middle of a line
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      clr_stats();
      drive_line(800, 0, 0);
      cyc(1'b1, 1'b0, 8'h00);
      chk("t5_line_end", 32'(a_le), 1);
      chk("t5_fs",       32'(a_fs), 1);
      chk("t5_y",        32'(a_y), 0);
      chk("t5_err",      32'(a_err), 0);
      chk("t5_dv",       32'(a_dv), 0);
      cyc(1'b0, 1'b0, 8'h00);
      drive_line(1600, 200, 0);
      chk("t5_pix_bad",  32'(pix_bad), 0);
      chk("t5_le_bad",   32'(le_bad), 0);
      chk("t5_err_after",32'(a_err), 0);
      chk("t5_dv_cycles",32'(a_dv_cnt), 2400);

      // 6: height limit on the narrow instance
      cyc(1'b1, 1'b0, 8'h00);
      chk("t6_fs", 32'(b_fs), 1);
      cyc(1'b0, 1'b0, 8'h00);
      clr_stats();
      for (int l = 0; l < 900; l++) b_line(4);
      chk("t6_dv_cycles", 32'(b_dv_cnt), 3600);
      chk("t6_line_ends", 32'(b_le_cnt), 900);
      chk("t6_err_ok",    32'(b_err), 0);
      chk("t6_state",     32'(b_state), 32'(WAIT_VS));
      clr_stats();
      b_line(4);
      chk("t6_extra_dv",  32'(b_dv_cnt), 0);
      chk("t6_extra_le",  32'(b_le_cnt), 0);
      chk("t6_extra_err", 32'(b_err), 1);
      cyc(1'b1, 1'b0, 8'h00);
      chk("t6_recover_err", 32'(b_err), 0);
      cyc(1'b0, 1'b0, 8'h00);
      clr_stats();
      b_line(4);
      chk("t6_recover_dv",  32'(b_dv_cnt), 4);
      chk("t6_recover_le",  32'(b_le_cnt), 1);
      chk("t6_recover_err2",32'(b_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
